// File: rtl/ps2_rx_pkg.sv
// ============================================================================
// Module   : ps2_rx_pkg
// Brief    : Shared PS/2 definitions (state encodings, frame constants).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PS2_DEFS_SV
`define PS2_DEFS_SV

package ps2_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int         PS2_DATA_BITS      = 8;
  // Break prefix is consumed by the downstream make/break stage.
  localparam logic [7:0] PS2_SCANCODE_BREAK = 8'hF0;

endpackage

`endif

`default_nettype wire

// File: rtl/ps2_edge_sync.sv
// ============================================================================
// Module   : ps2_edge_sync
// Brief    : Synchronizes the PS/2 pins and produces a one-cycle falling-edge
//            strobe. Optional debounce of the clock pin: PS2_RX_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_sclr,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_data_s,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   prev_q, prev_d;
  logic                   clk_s;
  logic                   clk_lvl;

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign o_data_s = data_sync_q[SYNC_STAGES-1];

`ifdef PS2_RX_GLITCH_FILTER_EN
  logic       deb_q, deb_d;
  logic [1:0] deb_cnt_q, deb_cnt_d;

  // The debounced level only follows clk_s once it has differed for 4 cycles.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = 2'd0;
    if (clk_s != deb_q) begin
      if (deb_cnt_q == 2'd3) begin
        deb_d = clk_s;
      end else begin
        deb_cnt_d = deb_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      deb_q     <= 1'b1;
      deb_cnt_q <= 2'd0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign clk_lvl = deb_q;
`else
  assign clk_lvl = clk_s;
`endif

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], i_ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], i_ps2_data};
    prev_d      = clk_lvl;
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      prev_q      <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      prev_q      <= prev_d;
    end
  end

  assign o_fall = prev_q & ~clk_lvl;

endmodule

`default_nettype wire

// File: rtl/ps2_rx.sv
// ============================================================================
// Module   : ps2_rx
// Brief    : PS/2 device-to-host frame receiver with parity/stop/timeout
//            checking. Optional clock debounce: PS2_RX_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx
  import ps2_rx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_en,
  output logic       o_frame_err
);

  localparam int             TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]     LAST_BIT = 3'(PS2_DATA_BITS - 1);

  logic data_s;
  logic fall;

  ps2_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk        (clk),
    .i_sclr     (i_sclr),
    .i_ps2_clk  (i_ps2_clk),
    .i_ps2_data (i_ps2_data),
    .o_data_s   (data_s),
    .o_fall     (fall)
  );

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_q, par_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_en_q, byte_en_d;
  logic          frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    sr_d        = sr_q;
    par_d       = par_q;
    byte_d      = byte_q;
    byte_en_d   = 1'b0;
    frame_err_d = 1'b0;

    // A fall in the terminal-count cycle takes priority over the timeout.
    if (fall) begin
      to_cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          sr_d      = {data_s, sr_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_s && (^{sr_q, par_q})) begin
            byte_d    = sr_q;
            byte_en_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        state_d     = IDLE;
        to_cnt_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      to_cnt_q    <= '0;
      sr_q        <= 8'h00;
      par_q       <= 1'b0;
      byte_q      <= 8'h00;
      byte_en_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      sr_q        <= sr_d;
      par_q       <= par_d;
      byte_q      <= byte_d;
      byte_en_q   <= byte_en_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_byte      = byte_q;
  assign o_byte_en   = byte_en_q;
  assign o_frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx.sv
// ============================================================================
// Module   : tb_ps2_rx
// Brief    : Directed self-checking bench for ps2_rx (TIMEOUT_CYCLES=200).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_rx;

  localparam int TO_CYC = 200;
  localparam int HALF   = 50;

  logic       clk = 1'b0;
  logic       i_sclr = 1'b1;
  logic       i_ps2_clk = 1'b1;
  logic       i_ps2_data = 1'b1;
  logic [7:0] o_byte;
  logic       o_byte_en;
  logic       o_frame_err;

  int n_cmp = 0;
  int n_err = 0;

  int         en_cnt = 0;
  int         err_cnt = 0;
  int         bad_pulse = 0;
  logic       prev_en = 1'b0;
  logic       prev_fe = 1'b0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  ps2_rx #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk         (clk),
    .i_sclr      (i_sclr),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_data  (i_ps2_data),
    .o_byte      (o_byte),
    .o_byte_en   (o_byte_en),
    .o_frame_err (o_frame_err)
  );

  // Pulse monitor: counts strobes and flags overlap or stretched pulses.
  always @(negedge clk) begin
    if (o_byte_en) begin
      en_cnt++;
      got_q.push_back(o_byte);
    end
    if (o_frame_err) err_cnt++;
    if ((o_byte_en && o_frame_err) || (o_byte_en && prev_en) || (o_frame_err && prev_fe))
      bad_pulse++;
    prev_en = o_byte_en;
    prev_fe = o_frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data set while the line is high, sampled on the falling edge.
  task automatic send_bit(input logic b, input bit glitch);
    i_ps2_clk  = 1'b1;
    i_ps2_data = b;
    if (glitch) begin
      wait_clk(20);
      i_ps2_clk = 1'b0;
      wait_clk(2);
      i_ps2_clk = 1'b1;
      wait_clk(HALF - 22);
    end else begin
      wait_clk(HALF);
    end
    i_ps2_clk = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input bit glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(par, glitch);
    send_bit(stp, glitch);
    i_ps2_clk  = 1'b1;
    i_ps2_data = 1'b1;
  endtask

  initial begin
    int en0, err0, idx0;
    logic [7:0] b0, b1;

    wait_clk(3);
    @(negedge clk);
    chk("rst_byte", {24'd0, o_byte}, 32'h00);
    chk("rst_en", {31'd0, o_byte_en}, 32'd0);
    chk("rst_err", {31'd0, o_frame_err}, 32'd0);
    @(posedge clk); #1;
    i_sclr = 1'b0;
    wait_clk(10);

    // 0x1C: three ones -> odd parity bit 0
    en0 = en_cnt; err0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_clk(20);
    chk("f1c_en", en_cnt - en0, 1);
    chk("f1c_byte", {24'd0, o_byte}, 32'h1C);
    chk("f1c_err", err_cnt - err0, 0);

    // 0xF0 (four ones -> parity 1) immediately followed by 0x1C
    en0 = en_cnt; err0 = err_cnt; idx0 = got_q.size();
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_clk(20);
    b0 = (got_q.size() > idx0)     ? got_q[idx0]     : 8'h00;
    b1 = (got_q.size() > idx0 + 1) ? got_q[idx0 + 1] : 8'h00;
    chk("b2b_en", en_cnt - en0, 2);
    chk("b2b_first", {24'd0, b0}, 32'hF0);
    chk("b2b_second", {24'd0, b1}, 32'h1C);
    chk("b2b_err", err_cnt - err0, 0);

    // 0x58 has three ones; parity 1 makes the total even
    en0 = en_cnt; err0 = err_cnt;
    send_frame(8'h58, 1'b1, 1'b1, 1'b0);
    wait_clk(20);
    chk("par_err", err_cnt - err0, 1);
    chk("par_en", en_cnt - en0, 0);
    chk("par_byte", {24'd0, o_byte}, 32'h1C);

    en0 = en_cnt; err0 = err_cnt;
    send_frame(8'h58, 1'b0, 1'b0, 1'b0);
    wait_clk(20);
    chk("stop_err", err_cnt - err0, 1);
    chk("stop_en", en_cnt - en0, 0);
    chk("stop_byte", {24'd0, o_byte}, 32'h1C);

    // Partial frame (start + 3 bits), then line idles past the timeout
    en0 = en_cnt; err0 = err_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    i_ps2_clk = 1'b1;
    wait_clk(TO_CYC + 100);
    chk("to_err", err_cnt - err0, 1);
    chk("to_en", en_cnt - en0, 0);
    en0 = en_cnt;
    send_frame(8'h58, 1'b0, 1'b1, 1'b0);
    wait_clk(20);
    chk("to_next_en", en_cnt - en0, 1);
    chk("to_next_byte", {24'd0, o_byte}, 32'h58);

    // Reset mid-frame after the 5th data bit
    err0 = err_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'(i % 2), 1'b0);
    i_ps2_clk = 1'b1;
    wait_clk(10);
    i_sclr = 1'b1;
    @(posedge clk); #1;
    i_sclr = 1'b0;
    @(negedge clk);
    chk("sclr_byte", {24'd0, o_byte}, 32'h00);
    chk("sclr_en", {31'd0, o_byte_en}, 32'd0);
    chk("sclr_err", {31'd0, o_frame_err}, 32'd0);
    wait_clk(TO_CYC + 100);
    chk("sclr_no_err", err_cnt - err0, 0);
    en0 = en_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_clk(20);
    chk("sclr_next_en", en_cnt - en0, 1);
    chk("sclr_next_byte", {24'd0, o_byte}, 32'h1C);

    // 2-cycle low glitches in every high phase of a 0x1C frame
    en0 = en_cnt; err0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    wait_clk(TO_CYC + 100);
`ifdef PS2_RX_GLITCH_FILTER_EN
    chk("glitch_en", en_cnt - en0, 1);
    chk("glitch_byte", {24'd0, o_byte}, 32'h1C);
    chk("glitch_err", err_cnt - err0, 0);
`else
    chk("glitch_seen",
        {31'd0, ((err_cnt - err0) != 0) || ((en_cnt - en0) != 1) || (o_byte != 8'h1C)},
        32'd1);
`endif

    chk("pulse_shape", bad_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
